multicycle_controller: RTL and testbench

// - Multi-cycle sequencer for the MIPS datapath. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
// - Drives instruction and data memory handshakes, and the IR/PC write strobes.
// - Drives ALUControl (same ALUOp->Funct decode as the control unit) and a single-cycle RegWrite pulse.
// - Counts retired instructions. Traps on an illegal opcode or a memory timeout.

---
 rtl/multicycle_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// drives the memory handshakes and datapath strobes, counts retirements and traps on faults.
module multicycle_controller #(
  parameter int COUNT_WIDTH = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [5:0]             Opcode,
  input  logic [5:0]             Funct,
  input  logic                   Zero,
  input  logic                   IMemAck,
  input  logic                   DMemAck,
  output logic                   IMemReq,
  output logic                   DMemReq,
  output logic                   DMemWrite,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   PCSrcBranch,
  output logic                   ALUSrcImm,
  output logic                   RegDst,
  output logic                   MemToReg,
  output logic [3:0]             ALUControl,
  output logic                   RegWrite,
  output logic                   Trap,
  output logic [COUNT_WIDTH-1:0] InstrRetired
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    I_RTYPE,
    I_LW,
    I_SW,
    I_BEQ
  } instr_e;

  state_e                 state_q, state_d;
  instr_e                 instr_q, instr_d;
  logic [3:0]             alu_ctrl_q, alu_ctrl_d;
  logic                   funct_ok_q, funct_ok_d;
  logic [TO_W-1:0]        timeout_q, timeout_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;

  logic       dec_legal;
  instr_e     dec_instr;
  logic [1:0] dec_alu_op;
  logic       dec_funct_ok;
  logic [3:0] dec_alu_ctrl;

  logic       imem_req_c, dmem_req_c, dmem_write_c, ir_write_c, pc_write_c, pc_src_c;
  logic       alu_src_imm_c, reg_dst_c, mem_to_reg_c, reg_write_c, trap_c, retire_c;
  logic [3:0] alu_ctrl_c;

  // Opcode classification and the ALUOp -> ALUControl decode, used while in DECODE.
  // NOTE: every signal written in an always_comb gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    dec_legal  = 1'b1;
    dec_instr  = I_RTYPE;
    dec_alu_op = ALUOP_ADD;
    case (Opcode)
      OP_RTYPE: begin dec_instr = I_RTYPE; dec_alu_op = ALUOP_FUNCT; end
      OP_LW:    begin dec_instr = I_LW;    dec_alu_op = ALUOP_ADD;   end
      OP_SW:    begin dec_instr = I_SW;    dec_alu_op = ALUOP_ADD;   end
      OP_BEQ:   begin dec_instr = I_BEQ;   dec_alu_op = ALUOP_SUB;   end
      default:  dec_legal = 1'b0;
    endcase

    dec_funct_ok = 1'b1;
    dec_alu_ctrl = ALU_ADD;
    case (dec_alu_op)
      ALUOP_ADD: dec_alu_ctrl = ALU_ADD;
      ALUOP_SUB: dec_alu_ctrl = ALU_SUB;
      default: begin
        case (Funct)
          FN_ADD:  dec_alu_ctrl = ALU_ADD;
          FN_SUB:  dec_alu_ctrl = ALU_SUB;
          FN_AND:  dec_alu_ctrl = ALU_AND;
          FN_OR:   dec_alu_ctrl = ALU_OR;
          FN_SLT:  dec_alu_ctrl = ALU_SLT;
          default: begin dec_funct_ok = 1'b0; dec_alu_ctrl = ALU_AND; end
        endcase
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    alu_ctrl_d    = alu_ctrl_q;
    funct_ok_d    = funct_ok_q;
    timeout_d     = '0;
    retired_d     = retired_q;
    imem_req_c    = 1'b0;
    dmem_req_c    = 1'b0;
    dmem_write_c  = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    pc_src_c      = 1'b0;
    alu_src_imm_c = 1'b0;
    reg_dst_c     = 1'b0;
    mem_to_reg_c  = 1'b0;
    reg_write_c   = 1'b0;
    trap_c        = 1'b0;
    retire_c      = 1'b0;
    alu_ctrl_c    = 4'b0000;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (IMemAck) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        // The wait that would bring the counter to MEM_TIMEOUT traps instead; an ack in it wins.
        end else if (timeout_q == TO_LAST) begin
          state_d = S_TRAP;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end

      S_DECODE: begin
        if (dec_legal) begin
          instr_d    = dec_instr;
          alu_ctrl_d = dec_alu_ctrl;
          funct_ok_d = dec_funct_ok;
          state_d    = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
        end
      end

      S_EXECUTE: begin
        alu_ctrl_c = alu_ctrl_q;
        case (instr_q)
          I_RTYPE: state_d = funct_ok_q ? S_WRITEBACK : S_TRAP;
          I_LW, I_SW: begin
            alu_src_imm_c = 1'b1;
            state_d       = S_MEM;
          end
          default: begin
            pc_write_c = Zero;
            pc_src_c   = Zero;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        alu_ctrl_c   = alu_ctrl_q;
        dmem_req_c   = 1'b1;
        dmem_write_c = (instr_q == I_SW);
        if (DMemAck) begin
          retire_c = (instr_q == I_SW);
          state_d  = (instr_q == I_SW) ? S_FETCH : S_WRITEBACK;
        end else if (timeout_q == TO_LAST) begin
          state_d = S_TRAP;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end

      S_WRITEBACK: begin
        alu_ctrl_c   = alu_ctrl_q;
        reg_write_c  = 1'b1;
        reg_dst_c    = (instr_q == I_RTYPE);
        mem_to_reg_c = (instr_q == I_LW);
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end

      default: begin
        trap_c  = 1'b1;
        state_d = S_TRAP;
      end
    endcase

    if (retire_c) retired_d = retired_q + COUNT_WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its inputs, independent of the order of statements.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_FETCH;
      instr_q    <= I_RTYPE;
      alu_ctrl_q <= 4'b0000;
      funct_ok_q <= 1'b0;
      timeout_q  <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      alu_ctrl_q <= alu_ctrl_d;
      funct_ok_q <= funct_ok_d;
      timeout_q  <= timeout_d;
      retired_q  <= retired_d;
    end
  end

  // Outputs read 0 for as long as RESET is held, even before the state register has reset.
  assign IMemReq      = imem_req_c    & ~RESET;
  assign DMemReq      = dmem_req_c    & ~RESET;
  assign DMemWrite    = dmem_write_c  & ~RESET;
  assign IRWrite      = ir_write_c    & ~RESET;
  assign PCWrite      = pc_write_c    & ~RESET;
  assign PCSrcBranch  = pc_src_c      & ~RESET;
  assign ALUSrcImm    = alu_src_imm_c & ~RESET;
  assign RegDst       = reg_dst_c     & ~RESET;
  assign MemToReg     = mem_to_reg_c  & ~RESET;
  assign RegWrite     = reg_write_c   & ~RESET;
  assign Trap         = trap_c        & ~RESET;
  assign ALUControl   = alu_ctrl_c    & {4{~RESET}};
  assign InstrRetired = retired_q     & {COUNT_WIDTH{~RESET}};

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: a per-instruction cycle model builds the expected output trace,
// which is replayed against two controllers (16-bit and 4-bit retire counters).
module tb_multicycle_controller;

  localparam int MEM_TIMEOUT = 255;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BAD = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src_imm;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [3:0] alu;
    logic       reg_write;
    logic       trap;
  } obs_t;

  localparam obs_t FULL = '1;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         rst;
    bit         ia;
    bit         da;
    bit         z;
    bit         retire;
    obs_t       exp;
    obs_t       mask;
  } cyc_t;

  typedef struct {
    obs_t        got;
    obs_t        got4;
    obs_t        exp;
    obs_t        mask;
    logic [15:0] ret;
    logic [3:0]  ret4;
    logic [15:0] exp_ret;
  } res_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [5:0]  Opcode = 6'd0;
  logic [5:0]  Funct = 6'd0;
  logic        Zero = 1'b0;
  logic        IMemAck = 1'b0;
  logic        DMemAck = 1'b0;

  logic        IMemReq, DMemReq, DMemWrite, IRWrite, PCWrite, PCSrcBranch;
  logic        ALUSrcImm, RegDst, MemToReg, RegWrite, Trap;
  logic [3:0]  ALUControl;
  logic [15:0] InstrRetired;

  logic        w4_IMemReq, w4_DMemReq, w4_DMemWrite, w4_IRWrite, w4_PCWrite, w4_PCSrcBranch;
  logic        w4_ALUSrcImm, w4_RegDst, w4_MemToReg, w4_RegWrite, w4_Trap;
  logic [3:0]  w4_ALUControl;
  logic [3:0]  w4_InstrRetired;

  obs_t obs_main, obs_w4;
  assign obs_main = {IMemReq, DMemReq, DMemWrite, IRWrite, PCWrite, PCSrcBranch, ALUSrcImm,
                     RegDst, MemToReg, ALUControl, RegWrite, Trap};
  assign obs_w4   = {w4_IMemReq, w4_DMemReq, w4_DMemWrite, w4_IRWrite, w4_PCWrite, w4_PCSrcBranch,
                     w4_ALUSrcImm, w4_RegDst, w4_MemToReg, w4_ALUControl, w4_RegWrite, w4_Trap};

  multicycle_controller #(.COUNT_WIDTH(16), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .IMemAck(IMemAck), .DMemAck(DMemAck), .IMemReq(IMemReq), .DMemReq(DMemReq),
    .DMemWrite(DMemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrcBranch(PCSrcBranch),
    .ALUSrcImm(ALUSrcImm), .RegDst(RegDst), .MemToReg(MemToReg), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .Trap(Trap), .InstrRetired(InstrRetired)
  );

  multicycle_controller #(.COUNT_WIDTH(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut_w4 (
    .CLK(CLK), .RESET(RESET), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .IMemAck(IMemAck), .DMemAck(DMemAck), .IMemReq(w4_IMemReq), .DMemReq(w4_DMemReq),
    .DMemWrite(w4_DMemWrite), .IRWrite(w4_IRWrite), .PCWrite(w4_PCWrite),
    .PCSrcBranch(w4_PCSrcBranch), .ALUSrcImm(w4_ALUSrcImm), .RegDst(w4_RegDst),
    .MemToReg(w4_MemToReg), .ALUControl(w4_ALUControl), .RegWrite(w4_RegWrite),
    .Trap(w4_Trap), .InstrRetired(w4_InstrRetired)
  );

  always #5 CLK = ~CLK;

  cyc_t        sched[$];
  res_t        res[$];
  int          checks;
  int          errors;
  logic [15:0] exp_ret;
  logic [5:0]  r_fns [5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  logic [5:0]  ops   [4] = '{OP_R, OP_LW, OP_SW, OP_BEQ};

  function automatic bit rb();
    return ($urandom & 1) != 0;
  endfunction

  // {legal, ALUControl} for an R-type Funct.
  function automatic logic [4:0] r_alu(input logic [5:0] fn);
    case (fn)
      FN_ADD:  r_alu = 5'b1_0010;
      FN_SUB:  r_alu = 5'b1_0110;
      FN_AND:  r_alu = 5'b1_0000;
      FN_OR:   r_alu = 5'b1_0001;
      FN_SLT:  r_alu = 5'b1_0111;
      default: r_alu = 5'b0_0000;
    endcase
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input obs_t e, input obs_t m,
                      input bit rst, input bit ia, input bit da, input bit z, input bit ret);
    cyc_t c;
    c.op = op; c.fn = fn; c.exp = e; c.mask = m;
    c.rst = rst; c.ia = ia; c.da = da; c.z = z; c.retire = ret;
    sched.push_back(c);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) push(6'($urandom), 6'($urandom), '0, FULL, 1'b1, rb(), rb(), rb(), 1'b0);
  endtask

  task automatic add_trap();
    obs_t e;
    e = '0; e.trap = 1'b1;
    for (int i = 0; i < 6; i++) push(6'($urandom), 6'($urandom), e, FULL, 1'b0, rb(), rb(), rb(), 1'b0);
  endtask

  task automatic add_idle();
    obs_t e;
    e = '0; e.imem_req = 1'b1;
    push(6'($urandom), 6'($urandom), e, FULL, 1'b0, 1'b0, rb(), rb(), 1'b0);
  endtask

  // Expected per-cycle trace of one instruction; a delay of MEM_TIMEOUT or more means no ack.
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int fdelay,
                           input int mdelay, input bit z);
    obs_t e, m;
    bit is_r, is_lw, is_sw, is_beq;
    logic [4:0] ra;
    logic [3:0] alu;
    is_r = (op == OP_R); is_lw = (op == OP_LW); is_sw = (op == OP_SW); is_beq = (op == OP_BEQ);
    ra = r_alu(fn);
    alu = is_r ? ra[3:0] : (is_beq ? 4'b0110 : 4'b0010);
    for (int i = 0; i < fdelay && i < MEM_TIMEOUT; i++) begin
      e = '0; e.imem_req = 1'b1;
      push(op, fn, e, FULL, 1'b0, 1'b0, rb(), rb(), 1'b0);
    end
    if (fdelay >= MEM_TIMEOUT) begin add_trap(); return; end
    e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(op, fn, e, FULL, 1'b0, 1'b1, rb(), rb(), 1'b0);
    push(op, fn, '0, FULL, 1'b0, rb(), rb(), rb(), 1'b0);
    if (!(is_r || is_lw || is_sw || is_beq)) begin add_trap(); return; end
    e = '0; e.alu = alu; e.alu_src_imm = is_lw | is_sw;
    e.pc_write = is_beq & z; e.pc_src = is_beq & z;
    if (is_r && !ra[4]) begin
      m = FULL; m.alu = '0;
      push(op, fn, e, m, 1'b0, rb(), rb(), z, 1'b0);
      add_trap();
      return;
    end
    push(op, fn, e, FULL, 1'b0, rb(), rb(), z, is_beq);
    if (is_beq) return;
    if (is_lw || is_sw) begin
      e = '0; e.alu = alu; e.dmem_req = 1'b1; e.dmem_write = is_sw;
      for (int i = 0; i < mdelay && i < MEM_TIMEOUT; i++) push(op, fn, e, FULL, 1'b0, rb(), 1'b0, rb(), 1'b0);
      if (mdelay >= MEM_TIMEOUT) begin add_trap(); return; end
      push(op, fn, e, FULL, 1'b0, rb(), 1'b1, rb(), is_sw);
      if (is_sw) return;
    end
    e = '0; e.alu = alu; e.reg_write = 1'b1; e.reg_dst = is_r; e.mem_to_reg = is_lw;
    push(op, fn, e, FULL, 1'b0, rb(), rb(), rb(), 1'b1);
  endtask

  // Replays the schedule; inputs change #1 after posedge, outputs are sampled at negedge.
  task automatic run_sched();
    res.delete();
    while (sched.size() > 0) begin
      cyc_t c;
      res_t r;
      c = sched.pop_front();
      RESET = c.rst; Opcode = c.op; Funct = c.fn; Zero = c.z; IMemAck = c.ia; DMemAck = c.da;
      @(negedge CLK);
      r.got = obs_main; r.got4 = obs_w4; r.exp = c.exp; r.mask = c.mask;
      r.ret = InstrRetired; r.ret4 = w4_InstrRetired;
      r.exp_ret = c.rst ? 16'd0 : exp_ret;
      res.push_back(r);
      if (c.rst) exp_ret = '0;
      else if (c.retire) exp_ret = exp_ret + 16'd1;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    add_reset(2);
    add_idle();
    run_sched();
    foreach (res[i]) begin
      checks++;
      if ((((res[i].got ^ res[i].exp) & res[i].mask) !== 15'd0) || (((res[i].got4 ^ res[i].exp) & res[i].mask) !== 15'd0) ||
          res[i].ret !== res[i].exp_ret || res[i].ret4 !== res[i].exp_ret[3:0]) begin
        errors++;
        $display("FAIL reset cycle %0d: obs=%h/%h ret=%0d/%0d expected obs=%h ret=%0d mask=%h",
                 i, res[i].got, res[i].got4, res[i].ret, res[i].ret4, res[i].exp, res[i].exp_ret, res[i].mask);
      end
    end
  endtask

  task automatic test_rtype_add();
    add_reset(1);
    add_instr(OP_R, FN_ADD, 0, 0, rb());
    add_idle();
    run_sched();
    foreach (res[i]) begin
      checks++;
      if ((((res[i].got ^ res[i].exp) & res[i].mask) !== 15'd0) || (((res[i].got4 ^ res[i].exp) & res[i].mask) !== 15'd0) ||
          res[i].ret !== res[i].exp_ret || res[i].ret4 !== res[i].exp_ret[3:0]) begin
        errors++;
        $display("FAIL rtype cycle %0d: obs=%h/%h ret=%0d/%0d expected obs=%h ret=%0d mask=%h",
                 i, res[i].got, res[i].got4, res[i].ret, res[i].ret4, res[i].exp, res[i].exp_ret, res[i].mask);
      end
    end
    checks++;
    if (res[1].got.ir_write !== 1'b1 || res[1].got.pc_write !== 1'b1 || res[3].got.alu !== 4'b0010 ||
        res[4].got.reg_write !== 1'b1 || res[5].ret !== 16'd1) begin
      errors++;
      $display("FAIL rtype_timeline: irw=%b pcw=%b alu=%b rw=%b ret=%0d expected 1 1 0010 1 1",
               res[1].got.ir_write, res[1].got.pc_write, res[3].got.alu, res[4].got.reg_write, res[5].ret);
    end
  endtask

  task automatic test_lw_wait();
    int n_dreq, n_rw, n_dw;
    add_reset(1);
    add_instr(OP_LW, 6'($urandom), $urandom_range(0, 3), 2, rb());
    add_idle();
    run_sched();
    n_dreq = 0; n_rw = 0; n_dw = 0;
    foreach (res[i]) begin
      checks++;
      if ((((res[i].got ^ res[i].exp) & res[i].mask) !== 15'd0) || (((res[i].got4 ^ res[i].exp) & res[i].mask) !== 15'd0) ||
          res[i].ret !== res[i].exp_ret || res[i].ret4 !== res[i].exp_ret[3:0]) begin
        errors++;
        $display("FAIL lw cycle %0d: obs=%h/%h ret=%0d/%0d expected obs=%h ret=%0d mask=%h",
                 i, res[i].got, res[i].got4, res[i].ret, res[i].ret4, res[i].exp, res[i].exp_ret, res[i].mask);
      end
      if (res[i].got.dmem_req === 1'b1) n_dreq++;
      if (res[i].got.dmem_write === 1'b1) n_dw++;
      if (res[i].got.reg_write === 1'b1 && res[i].got.mem_to_reg === 1'b1) n_rw++;
    end
    checks++;
    if (n_dreq != 3 || n_rw != 1 || n_dw != 0) begin
      errors++;
      $display("FAIL lw_counts: dmem_req=%0d regwrite_memtoreg=%0d dmem_write=%0d expected 3 1 0", n_dreq, n_rw, n_dw);
    end
  endtask

  task automatic test_beq();
    int n_br, n_rw;
    add_reset(1);
    add_instr(OP_BEQ, 6'($urandom), $urandom_range(0, 3), 0, 1'b1);
    add_instr(OP_BEQ, 6'($urandom), $urandom_range(0, 3), 0, 1'b0);
    add_idle();
    run_sched();
    n_br = 0; n_rw = 0;
    foreach (res[i]) begin
      checks++;
      if ((((res[i].got ^ res[i].exp) & res[i].mask) !== 15'd0) || (((res[i].got4 ^ res[i].exp) & res[i].mask) !== 15'd0) ||
          res[i].ret !== res[i].exp_ret || res[i].ret4 !== res[i].exp_ret[3:0]) begin
        errors++;
        $display("FAIL beq cycle %0d: obs=%h/%h ret=%0d/%0d expected obs=%h ret=%0d mask=%h",
                 i, res[i].got, res[i].got4, res[i].ret, res[i].ret4, res[i].exp, res[i].exp_ret, res[i].mask);
      end
      if (res[i].got.pc_src === 1'b1) n_br++;
      if (res[i].got.reg_write === 1'b1) n_rw++;
    end
    checks++;
    if (n_br != 1 || n_rw != 0 || res[res.size()-1].ret !== 16'd2) begin
      errors++;
      $display("FAIL beq_summary: branches=%0d regwrites=%0d retired=%0d expected 1 0 2",
               n_br, n_rw, res[res.size()-1].ret);
    end
  endtask

  task automatic test_illegal();
    add_reset(1);
    add_instr(OP_R, FN_OR, $urandom_range(0, 2), 0, rb());
    add_instr(OP_BAD, 6'($urandom), 0, 0, rb());
    add_reset(1);
    add_instr(OP_R, 6'b000000, 0, 0, rb());
    run_sched();
    foreach (res[i]) begin
      checks++;
      if ((((res[i].got ^ res[i].exp) & res[i].mask) !== 15'd0) || (((res[i].got4 ^ res[i].exp) & res[i].mask) !== 15'd0) ||
          res[i].ret !== res[i].exp_ret || res[i].ret4 !== res[i].exp_ret[3:0]) begin
        errors++;
        $display("FAIL illegal cycle %0d: obs=%h/%h ret=%0d/%0d expected obs=%h ret=%0d mask=%h",
                 i, res[i].got, res[i].got4, res[i].ret, res[i].ret4, res[i].exp, res[i].exp_ret, res[i].mask);
      end
    end
  endtask

  task automatic test_timeout();
    add_reset(1);
    add_instr(OP_R, FN_ADD, MEM_TIMEOUT, 0, 1'b0);
    add_reset(1);
    add_instr(OP_R, FN_SUB, MEM_TIMEOUT - 1, 0, 1'b0);
    add_instr(OP_SW, 6'($urandom), 200, MEM_TIMEOUT, 1'b0);
    run_sched();
    foreach (res[i]) begin
      checks++;
      if ((((res[i].got ^ res[i].exp) & res[i].mask) !== 15'd0) || (((res[i].got4 ^ res[i].exp) & res[i].mask) !== 15'd0) ||
          res[i].ret !== res[i].exp_ret || res[i].ret4 !== res[i].exp_ret[3:0]) begin
        errors++;
        $display("FAIL timeout cycle %0d: obs=%h/%h ret=%0d/%0d expected obs=%h ret=%0d mask=%h",
                 i, res[i].got, res[i].got4, res[i].ret, res[i].ret4, res[i].exp, res[i].exp_ret, res[i].mask);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    int n;
    add_reset(1);
    add_instr(OP_SW, 6'($urandom), 0, 0, rb());
    n = sched.size();
    add_instr(OP_LW, 6'($urandom), 0, 10, rb());
    while (sched.size() > n + 5) void'(sched.pop_back());
    add_reset(1);
    add_idle();
    add_instr(OP_R, FN_AND, 1, 0, rb());
    add_idle();
    run_sched();
    foreach (res[i]) begin
      checks++;
      if ((((res[i].got ^ res[i].exp) & res[i].mask) !== 15'd0) || (((res[i].got4 ^ res[i].exp) & res[i].mask) !== 15'd0) ||
          res[i].ret !== res[i].exp_ret || res[i].ret4 !== res[i].exp_ret[3:0]) begin
        errors++;
        $display("FAIL reset_mid_mem cycle %0d: obs=%h/%h ret=%0d/%0d expected obs=%h ret=%0d mask=%h",
                 i, res[i].got, res[i].got4, res[i].ret, res[i].ret4, res[i].exp, res[i].exp_ret, res[i].mask);
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    add_reset(1);
    for (int k = 0; k < 17; k++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ops[$urandom_range(0, 3)];
      fn = (op == OP_R) ? r_fns[$urandom_range(0, 4)] : 6'($urandom);
      add_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), rb());
    end
    add_idle();
    run_sched();
    foreach (res[i]) begin
      checks++;
      if ((((res[i].got ^ res[i].exp) & res[i].mask) !== 15'd0) || (((res[i].got4 ^ res[i].exp) & res[i].mask) !== 15'd0) ||
          res[i].ret !== res[i].exp_ret || res[i].ret4 !== res[i].exp_ret[3:0]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: obs=%h/%h ret=%0d/%0d expected obs=%h ret=%0d mask=%h",
                 i, res[i].got, res[i].got4, res[i].ret, res[i].ret4, res[i].exp, res[i].exp_ret, res[i].mask);
      end
    end
    checks++;
    if (res[res.size()-1].ret4 !== 4'd1 || res[res.size()-1].ret !== 16'd17) begin
      errors++;
      $display("FAIL wrap: retired4=%0d retired16=%0d expected 1 17",
               res[res.size()-1].ret4, res[res.size()-1].ret);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_ret = '0;
    @(posedge CLK);
    #1;
    test_reset();
    test_rtype_add();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
